times_table_arbiter: RTL
========================

TIMES_TABLE_ARBITER -- requirements
Module: times_table_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 1: memory read latency in cycles from the mem_en sample edge to valid mem_dout; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has a lookup pending.
REQ-005 req0_a, req0_b  input  3 each  requester 0 operands, 0..7.
REQ-006 req0_ready  output  1  requester 0 lookup accepted this cycle.
REQ-007 rsp0_valid  output  1  requester 0 result available.
REQ-008 rsp0_ready  input  1  requester 0 consumes the result.
REQ-009 rsp0_result  output  6  product for requester 0.
REQ-010 req1_*, rsp1_*  same directions and widths as REQ-004..REQ-009  requester 1.
REQ-011 mem_en  output  1  lookup-memory read enable.
REQ-012 mem_addr  output  6  lookup-memory address, {a,b}, with a in bits [5:3].
REQ-013 mem_dout  input  6  lookup-memory read data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, READ, WAIT and RESP, with one transaction outstanding at a time.
REQ-016 In IDLE, at most one reqN_ready SHALL be high, and only for a requester with reqN_valid high; all reqN_ready SHALL be low in every other state.
REQ-017 Grants SHALL be round-robin: when both requesters are valid, the one not granted last wins; a lone valid requester always wins.
REQ-018 A handshake (valid and ready both high at an edge) SHALL capture {a,b} and the owner ID, then move IDLE->READ.
REQ-019 In READ, mem_en SHALL be 1 and mem_addr SHALL equal the captured address for exactly one cycle, then READ->WAIT.
REQ-020 WAIT SHALL last exactly LAT cycles; at the final WAIT edge, mem_dout SHALL be registered into the owner's result register, then WAIT->RESP.
REQ-021 rsp_valid SHALL rise LAT+2 cycles after the accept edge (3 cycles for LAT=1).
REQ-022 In RESP, only the owner's rspN_valid SHALL be high, and its rspN_result SHALL stay stable until an edge with rspN_ready high.
REQ-023 On the rspN_ready edge, the FSM SHALL move RESP->IDLE, and a new grant is possible in the very next cycle.
REQ-024 The block SHALL have no timeout: with rspN_ready held low, RESP persists indefinitely and the other requester stays stalled.
REQ-025 Outside READ, mem_en SHALL be 0 and mem_addr SHALL hold its last value.
REQ-026 The non-owner's rsp_valid SHALL always be 0, and its result output SHALL hold its previous value.
REQ-027 A requester dropping reqN_valid while not granted SHALL have no effect on state.
REQ-028 reqN_a and reqN_b SHALL be ignored except on the accept edge.
REQ-029 Operand boundaries 0 and 7 SHALL need no special handling: address 6'd0 maps to 0 and 6'd63 maps to 49.

Reset
REQ-030 While rst_n is low, the block SHALL force: state IDLE; round-robin pointer favouring requester 0; mem_en 0; mem_addr 0; both rsp_valid 0; both rsp_result 0; both req_ready 0; busy 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no response delivered.
REQ-032 After rst_n deasserts, the first grant SHALL be evaluated in the following IDLE cycle.

Verification
REQ-033 Single request, LAT=1: req0 a=3, b=5 accepted at edge T -> mem_en=1 with addr 6'o35 in cycle T+1; rsp0_valid=1 with result 15 at T+3; rsp1_valid stays 0.
REQ-034 Contention: both requesters valid continuously with rsp_ready=1 (req0 a=7,b=7; req1 a=2,b=6) -> grants alternate 0,1,0,1 and results alternate 49,12; no two grants fall within 4 cycles of each other.
REQ-035 Backpressure: rsp1_ready held low for 10 cycles during RESP -> rsp1_valid and rsp1_result=12 stay stable, req0_ready stays 0, busy=1; the transaction completes on the cycle rsp1_ready rises.
REQ-036 Reset mid-operation: rst_n pulsed low during WAIT -> all outputs go to their reset values immediately; no rsp_valid afterwards; the next tied request goes to requester 0.
REQ-037 LAT=3 build, req0 a=0, b=0 -> WAIT lasts 3 cycles, rsp0_valid rises 5 cycles after accept, result 0.
REQ-038 Exhaustive sweep: all 64 {a,b} pairs through requester 1, against a memory model that returns a*b -> every result equals a*b, and mem_en is asserted exactly 64 times.

Source files
------------

// File: rtl/times_table_arbiter.sv
// Two-requester round-robin front end for a shared multiplication-table memory.
// One lookup is in flight at a time: IDLE grants, READ issues, WAIT covers memory latency, RESP holds the result.
module times_table_arbiter #(
    parameter int LAT = 1  // memory read latency, 1..4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_a,
    input  logic [2:0] req0_b,
    output logic       req0_ready,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [5:0] rsp0_result,
    input  logic       req1_valid,
    input  logic [2:0] req1_a,
    input  logic [2:0] req1_b,
    output logic       req1_ready,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [5:0] rsp1_result,
    output logic       mem_en,
    output logic [5:0] mem_addr,
    input  logic [5:0] mem_dout,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(LAT - 1);

    state_t     state, state_nxt;
    logic       last_grant;  // ID granted most recently; the other one wins a tie
    logic       owner;
    logic [2:0] wait_cnt;
    logic       grant0, grant1, accept, wait_done, rsp_take;

    assign grant0    = req0_valid && (!req1_valid || last_grant);
    assign grant1    = req1_valid && (!req0_valid || !last_grant);
    assign accept    = (state == IDLE) && (grant0 || grant1);
    assign wait_done = (state == WAIT) && (wait_cnt == WAIT_LAST);
    assign rsp_take  = owner ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_en     = 1'b0;
        case (state)
            IDLE: begin
                // ready is gated by rst_n so nothing is granted while reset is held
                req0_ready = rst_n && grant0;
                req1_ready = rst_n && grant1;
                if (grant0 || grant1) state_nxt = READ;
            end
            READ: begin
                mem_en    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: if (wait_done) state_nxt = RESP;
            RESP: if (rsp_take)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) && owner;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            mem_addr    <= 6'd0;
            wait_cnt    <= 3'd0;
            rsp0_result <= 6'd0;
            rsp1_result <= 6'd0;
        end else begin
            if (accept) begin
                owner      <= grant1;
                last_grant <= grant1;
                mem_addr   <= grant1 ? {req1_a, req1_b} : {req0_a, req0_b};
            end
            if (state == READ)      wait_cnt <= 3'd0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 3'd1;
            if (wait_done) begin
                if (owner) rsp1_result <= mem_dout;
                else       rsp0_result <= mem_dout;
            end
        end
    end

endmodule
